// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key expansion block.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned NUM_WORDS  = 44;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned SCHED_W    = NUM_WORDS * WORD_W;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned RK_SEL_W   = 4;

    localparam logic [7:0] RCON [NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE_S = 2'd2
    } state_t;

    typedef logic [WORD_W-1:0] word_t;

    // Round constant for round r (0-based); out-of-range indices yield zero.
    function automatic logic [7:0] rcon_lookup(input logic [RK_SEL_W-1:0] r);
        return (r < RK_SEL_W'(NUM_ROUNDS)) ? RCON[r] : 8'h00;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expansion_if.sv
// Control and data bundle between a key-schedule consumer and aes_key_expansion.
interface aes_key_expansion_if;
    import aes_pkg::*;

    logic                   START;
    logic [KEY_W-1:0]       KEY;
    logic [RK_SEL_W-1:0]    RK_SEL;
    logic                   DONE;
    logic                   BUSY;
    logic [SCHED_W-1:0]     KEY_SCHEDULE;
    logic [KEY_W-1:0]       RK_OUT;

    modport master (
        output START, KEY, RK_SEL,
        input  DONE, BUSY, KEY_SCHEDULE, RK_OUT
    );

    modport slave (
        input  START, KEY, RK_SEL,
        output DONE, BUSY, KEY_SCHEDULE, RK_OUT
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[data];

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key expansion: captures a key on START and writes one schedule word per cycle.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    aes_key_expansion_if.slave  bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic                   capture;
    logic                   wr_en;
    logic                   done_q;
    logic                   done_nxt;
    logic                   busy_q;
    logic                   busy_nxt;

    word_t                  w [NUM_WORDS];
    word_t                  w_prev;
    word_t                  w_back;
    word_t                  rot;
    word_t                  sub;
    word_t                  temp;
    word_t                  w_new;
    logic [RK_SEL_W-1:0]    rcon_idx;
    logic [IDX_W-1:0]       rk_base;

    // State, index and status flags; DONE/BUSY trail the state by one edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            idx    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            done_q <= done_nxt;
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        wr_en     = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.START) begin
                    capture   = 1'b1;
                    idx_nxt   = IDX_W'(4);
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                busy_nxt = 1'b1;
                wr_en    = 1'b1;
                idx_nxt  = idx + IDX_W'(1);
                if (idx == IDX_W'(NUM_WORDS - 1)) begin
                    state_nxt = DONE_S;
                end
            end
            DONE_S: begin
                done_nxt = 1'b1;
                if (!bus.START) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next-word datapath for w[idx].
    assign w_prev   = w[idx - IDX_W'(1)];
    assign w_back   = w[idx - IDX_W'(4)];
    assign rot      = rot_word(w_prev);
    assign rcon_idx = idx[IDX_W-1:2] - RK_SEL_W'(1);

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data  (rot[8*b +: 8]),
            .subst (sub[8*b +: 8])
        );
    end

    assign temp  = (idx[1:0] == 2'b00) ? (sub ^ {rcon_lookup(rcon_idx), 24'h000000}) : w_prev;
    assign w_new = w_back ^ temp;

    // Word storage: key words load together on capture, otherwise one word per cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned k = 0; k < NUM_WORDS; k++) begin
                w[k] <= '0;
            end
        end else if (capture) begin
            w[0] <= bus.KEY[127:96];
            w[1] <= bus.KEY[95:64];
            w[2] <= bus.KEY[63:32];
            w[3] <= bus.KEY[31:0];
        end else if (wr_en) begin
            w[idx] <= w_new;
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_sched
        assign bus.KEY_SCHEDULE[SCHED_W - 1 - WORD_W*g -: WORD_W] = w[g];
    end

    // Round-key select; selections beyond the last round read as zero.
    assign rk_base    = {bus.RK_SEL, 2'b00};
    assign bus.RK_OUT = (bus.RK_SEL <= RK_SEL_W'(NUM_ROUNDS))
                      ? {w[rk_base], w[rk_base + IDX_W'(1)], w[rk_base + IDX_W'(2)], w[rk_base + IDX_W'(3)]}
                      : '0;

    assign bus.DONE = done_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion against a GF(2^8)-derived key schedule model.
module tb_aes_key_expansion;
    import aes_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N;

    aes_key_expansion_if bus ();

    aes_key_expansion dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1407:0] exp_q [$];
    logic [7:0]    sbox_m [256];
    logic [7:0]    rcon_m [10];
    bit            done_prev = 1'b0;

    localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK1_ZERO  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from multiplicative inverse plus affine map; RCON from repeated doubling.
    task automatic init_model();
        logic [7:0] r = 8'h01;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int k = 0; k < 10; k++) begin
            rcon_m[k] = r;
            r = xtime(r);
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [1407:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rcon_m[i/4 - 1], 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) s[1407 - 32*i -: 32] = w[i];
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_sched(input string name, input logic [1407:0] act, input logic [1407:0] exp);
        n_tests++;
        if (act !== exp) begin
            int bad = 0;
            for (int i = 43; i >= 0; i--)
                if (act[1407 - 32*i -: 32] !== exp[1407 - 32*i -: 32]) bad = i;
            n_fail++;
            $display("FAIL %s: w[%0d] got %h expected %h", name, bad,
                     act[1407 - 32*bad -: 32], exp[1407 - 32*bad -: 32]);
        end
    endtask

    // Monitor: every DONE rising edge must match the oldest outstanding expansion.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && bus.DONE === 1'b1 && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got DONE rise expected none");
            end else begin
                check_sched("sb_schedule", bus.KEY_SCHEDULE, exp_q.pop_front());
            end
        end
        done_prev = (bus.DONE === 1'b1);
    end

    // One expansion, sampling after each of the 44 edges that follow the capture edge.
    task automatic run(input logic [127:0] key, input bit preset,
                       input int drop_n, input int chg_n, input logic [127:0] new_key,
                       input int exp_done_cnt);
        int busy_cnt  = 0;
        int done_edge = 0;
        int done_cnt  = 0;
        if (!preset) begin
            @(negedge CLK);
            bus.KEY   = key;
            bus.START = 1'b1;
        end
        exp_q.push_back(expand(key));
        @(posedge CLK);
        for (int n = 1; n <= 44; n++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (bus.BUSY === 1'b1) busy_cnt++;
            if (bus.DONE === 1'b1) begin
                done_cnt++;
                if (done_edge == 0) done_edge = n;
            end
            if (n == drop_n) bus.START = 1'b0;
            if (n == chg_n)  bus.KEY   = new_key;
        end
        check("busy_cycles", 128'(busy_cnt), 128'(40));
        check("done_rise_edge", 128'(done_edge), 128'(41));
        check("done_cycles", 128'(done_cnt), 128'(exp_done_cnt));
    endtask

    task automatic release_start(input logic [127:0] key);
        bus.START = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_after_start_low", 128'(dut.state), 128'(IDLE));
        check_sched("sched_retained", bus.KEY_SCHEDULE, expand(key));
        repeat (3) @(negedge CLK);
        check("done_low_in_idle", 128'(bus.DONE), 128'(0));
        check("busy_low_in_idle", 128'(bus.BUSY), 128'(0));
    endtask

    task automatic check_rk(input logic [127:0] key);
        logic [1407:0] s = expand(key);
        for (int r = 0; r < 16; r++) begin
            bus.RK_SEL = 4'(r);
            #1;
            check($sformatf("rk_out_sel%0d", r), bus.RK_OUT,
                  (r <= 10) ? s[1407 - 128*r -: 128] : 128'd0);
        end
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] k2;
        init_model();
        RESET_N    = 1'b0;
        bus.START  = 1'b0;
        bus.KEY    = '0;
        bus.RK_SEL = '0;
        #1;
        check("reset_done", 128'(bus.DONE), 128'(0));
        check("reset_busy", 128'(bus.BUSY), 128'(0));
        check_sched("reset_schedule", bus.KEY_SCHEDULE, '0);
        check("reset_rk_out", bus.RK_OUT, 128'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        // All-zero key with START held high.
        run(128'd0, 1'b0, 0, 0, '0, 4);
        bus.RK_SEL = 4'd1;  #1; check("zero_key_rk1", bus.RK_OUT, RK1_ZERO);
        bus.RK_SEL = 4'd10; #1; check("zero_key_rk10", bus.RK_OUT, RK10_ZERO);
        check_rk(128'd0);
        release_start(128'd0);

        // FIPS-197 key.
        run(KEY_FIPS, 1'b0, 0, 0, '0, 4);
        check("fips_w4", 128'(bus.KEY_SCHEDULE[1407 - 128 -: 32]), 128'(32'ha0fafe17));
        bus.RK_SEL = 4'd10; #1; check("fips_rk10", bus.RK_OUT, RK10_FIPS);
        release_start(KEY_FIPS);

        // Reset at i=20 aborts; START held through release restarts on the first edge.
        k = {$urandom, $urandom, $urandom, $urandom};
        @(negedge CLK);
        bus.KEY   = k;
        bus.START = 1'b1;
        exp_q.push_back(expand(k));
        @(posedge CLK);
        repeat (16) @(posedge CLK);
        @(negedge CLK);
        check("idx_before_abort", 128'(dut.idx), 128'(20));
        RESET_N = 1'b0;
        #1;
        check("abort_done", 128'(bus.DONE), 128'(0));
        check("abort_busy", 128'(bus.BUSY), 128'(0));
        check("abort_state", 128'(dut.state), 128'(IDLE));
        check_sched("abort_schedule", bus.KEY_SCHEDULE, '0);
        exp_q.delete();
        @(negedge CLK);
        bus.KEY = KEY_FIPS;
        RESET_N = 1'b1;
        run(KEY_FIPS, 1'b1, 0, 0, '0, 4);
        check("rerun_w4", 128'(bus.KEY_SCHEDULE[1407 - 128 -: 32]), 128'(32'ha0fafe17));
        bus.RK_SEL = 4'd10; #1; check("rerun_rk10", bus.RK_OUT, RK10_FIPS);
        release_start(KEY_FIPS);

        // START dropped at i=10, KEY changed at i=12.
        k  = {$urandom, $urandom, $urandom, $urandom};
        k2 = ~k;
        run(k, 1'b0, 6, 8, k2, 1);
        repeat (3) @(negedge CLK);
        check("no_restart_busy", 128'(bus.BUSY), 128'(0));
        check_sched("drop_sched_original_key", bus.KEY_SCHEDULE, expand(k));
        check_rk(k);

        // Random keys.
        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run(k, 1'b0, 0, 0, '0, 4);
            check_rk(k);
            release_start(k);
        end

        bus.RK_SEL = 4'd11; #1; check("rk_sel11_zero", bus.RK_OUT, 128'd0);
        bus.RK_SEL = 4'd15; #1; check("rk_sel15_zero", bus.RK_OUT, 128'd0);

        repeat (2) @(negedge CLK);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expansion.md
AES_KEY_EXPANSION -- requirements
Module: aes_key_expansion

Interface
REQ-001 The block SHALL have one clock, CLK, and an asynchronous active-low reset, RESET_N.
REQ-002 Port CLK SHALL be an input, 1 bit wide, and SHALL clock all state on its rising edge.
REQ-003 Port RESET_N SHALL be an input, 1 bit wide, asynchronous and active-low, and SHALL return the block to IDLE.
REQ-004 Port START SHALL be an input, 1 bit wide, level-sensitive, driven from start-register bit 0.
REQ-005 Port KEY SHALL be an input, 128 bits wide, carrying the cipher key with w0 at KEY[127:96] and w3 at KEY[31:0].
REQ-006 Port RK_SEL SHALL be an input, 4 bits wide, selecting the round key (0..10) for RK_OUT.
REQ-007 Port DONE SHALL be an output, 1 bit wide, high while a complete schedule is held.
REQ-008 Port BUSY SHALL be an output, 1 bit wide, high while in state EXPAND.
REQ-009 Port KEY_SCHEDULE SHALL be an output, 1408 bits wide, with word w[i] at bits [1407-32i -: 32].
REQ-010 Port RK_OUT SHALL be an output, 128 bits wide, equal to {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r=RK_SEL, combinationally.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, EXPAND and DONE_S.
REQ-012 In IDLE with START=1 at a rising edge, the block SHALL capture KEY into w0..w3, set word index i=4 and enter EXPAND.
REQ-013 In EXPAND, the block SHALL write exactly one word w[i] per cycle for i=4..43 (40 cycles) and then enter DONE_S.
REQ-014 Word rule: temp=w[i-1]; if i mod 4 = 0 then temp=SubWord(RotWord(temp)) XOR {RCON[i/4-1], 24'h0}; w[i]=w[i-4] XOR temp.
REQ-015 RCON SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-016 RotWord SHALL be a left byte rotation, {b1,b2,b3,b0}; SubWord SHALL apply the AES S-box to each byte independently.
REQ-017 DONE SHALL rise exactly 41 rising edges after the edge that sampled START=1 in IDLE.
REQ-018 In DONE_S, DONE SHALL remain high and the FSM SHALL return to IDLE at the first edge where START=0.
REQ-019 The schedule SHALL be held unchanged in IDLE and DONE_S.
REQ-020 A new expansion SHALL require START to go low, then high again.
REQ-021 If START drops during EXPAND, expansion SHALL still complete; DONE SHALL then be high for exactly one cycle before IDLE.
REQ-022 KEY changes after the capture edge SHALL be ignored until the next expansion.
REQ-023 RK_SEL values 11..15 SHALL drive RK_OUT to all zeros.
REQ-024 During EXPAND, KEY_SCHEDULE and RK_OUT SHALL reflect partially written words; consumers SHALL qualify them with DONE.

Reset
REQ-025 On RESET_N=0, the block SHALL immediately (asynchronously) set state=IDLE, i=0, all w[0..43]=0, DONE=0 and BUSY=0.
REQ-026 Reset asserted mid-EXPAND SHALL abort the expansion, with no partial completion and no DONE pulse.
REQ-027 If START=1 at reset release, expansion SHALL begin at the first rising edge after release.

Structure
REQ-028 Package aes_pkg SHALL hold the state enum, the RCON array, NUM_ROUNDS=10 and NUM_WORDS=44.
REQ-029 The S-box SHALL be a combinational sub-module, aes_sbox (8-bit in, 8-bit out), instantiated four times for SubWord.
REQ-030 Word storage SHALL be a 44x32 register array with a single write port, indexed by i.

Verification
REQ-031 Bench scenario: KEY=2b7e151628aed2a6abf7158809cf4f3c -> w4=a0fafe17; RK_SEL=10 gives RK_OUT=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 Bench scenario: KEY=0 -> RK_SEL=1 gives 62636363626363636263636362636363; RK_SEL=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 Bench scenario: START held high -> BUSY is high for 40 cycles, DONE rises on edge 41 and stays high; START low -> IDLE on the next edge with the schedule retained.
REQ-034 Bench scenario: RESET_N pulsed low at i=20 -> DONE=0, KEY_SCHEDULE=0 and state=IDLE immediately; the rerun then matches REQ-031.
REQ-035 Bench scenario: START dropped at i=10 and KEY changed at i=12 -> the schedule matches the originally captured key and DONE is high for exactly one cycle.
REQ-036 Bench scenario: RK_SEL=11 and RK_SEL=15 -> RK_OUT=0.
